exe_muldiv: RTL and testbench

//   Multi-cycle RV32M/RV64M multiply/divide unit beside the combinational execution stage.

---
 rtl/exe_muldiv.sv | 164 ++++++++++++++++
 tb/tb_exe_muldiv.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_muldiv.sv
// exe_muldiv: iterative RV32M/RV64M multiply/divide unit.
// One bit per cycle: shift-add multiply, restoring divide, both on operand
// magnitudes with a final conditional negation. Divide-by-zero and signed
// overflow bypass the iteration and complete on the cycle after the request.
module exe_muldiv #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [4:0]      reg_wr_addr_i,
    input  logic            abort_i,
    output logic            hold_o,
    output logic            ready_o,
    output logic [XLEN-1:0] result_o,
    output logic            reg_wr_en_o,
    output logic [4:0]      reg_wr_addr_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [XLEN-1:0]  X_ZERO = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]  X_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]  X_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]  X_ONE  = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [2*XLEN-1:0] P_ONE = {{(2*XLEN-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN-1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]        state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [2:0]        op_r;
    logic              neg_r;
    logic [XLEN-1:0]   a_r;       // multiplicand or divisor magnitude
    logic [2*XLEN-1:0] prod_r;    // {acc, multiplier} or {remainder, quotient}
    logic [XLEN-1:0]   result_r;
    logic [4:0]        rd_r;

    logic              op1_sgn_s, op2_sgn_s, s1_s, s2_s, neg_s;
    logic [XLEN-1:0]   mag1_s, mag2_s;
    logic              div_zero_s, div_ovf_s, special_s;
    logic [XLEN-1:0]   spec_res_s;

    logic [XLEN:0]     mul_sum_s;
    logic [XLEN:0]     div_shift_s;
    logic [XLEN:0]     div_diff_s;
    logic [2*XLEN-1:0] prod_nxt_s;
    logic [2*XLEN-1:0] prod_sgn_s;
    logic [XLEN-1:0]   div_sel_s;
    logic [XLEN-1:0]   fin_s;

    // Decode the incoming request: signedness, magnitudes, result sign, special cases.
    always_comb begin
        op1_sgn_s = op_i[2] ? ~op_i[0] : (op_i[1:0] != 2'b11);
        op2_sgn_s = op_i[2] ? ~op_i[0] : ~op_i[1];
        s1_s      = op1_sgn_s & op1_i[XLEN-1];
        s2_s      = op2_sgn_s & op2_i[XLEN-1];
        mag1_s    = s1_s ? ((~op1_i) + X_ONE) : op1_i;
        mag2_s    = s2_s ? ((~op2_i) + X_ONE) : op2_i;
        // Remainder follows the dividend; everything else follows the sign product.
        neg_s      = (op_i[2] & op_i[1]) ? s1_s : (s1_s ^ s2_s);
        div_zero_s = op_i[2] & (op2_i == X_ZERO);
        div_ovf_s  = op_i[2] & ~op_i[0] & (op1_i == X_MIN) & (op2_i == X_ONES);
        special_s  = div_zero_s | div_ovf_s;
        if (div_zero_s) begin
            spec_res_s = op_i[1] ? op1_i : X_ONES;
        end else begin
            spec_res_s = op_i[1] ? X_ZERO : op1_i;
        end
    end

    // One iteration step of the shared shift register.
    always_comb begin
        mul_sum_s   = {1'b0, prod_r[2*XLEN-1:XLEN]} + (prod_r[0] ? {1'b0, a_r} : {(XLEN+1){1'b0}});
        div_shift_s = prod_r[2*XLEN-1:XLEN-1];
        div_diff_s  = div_shift_s - {1'b0, a_r};
        if (op_r[2]) begin
            if (!div_diff_s[XLEN]) begin
                prod_nxt_s = {div_diff_s[XLEN-1:0], prod_r[XLEN-2:0], 1'b1};
            end else begin
                prod_nxt_s = {div_shift_s[XLEN-1:0], prod_r[XLEN-2:0], 1'b0};
            end
        end else begin
            prod_nxt_s = {mul_sum_s, prod_r[XLEN-1:1]};
        end
    end

    // Apply the sign and select the architectural result from the final step.
    always_comb begin
        prod_sgn_s = neg_r ? ((~prod_nxt_s) + P_ONE) : prod_nxt_s;
        div_sel_s  = op_r[1] ? prod_nxt_s[2*XLEN-1:XLEN] : prod_nxt_s[XLEN-1:0];
        if (op_r[2]) begin
            fin_s = neg_r ? ((~div_sel_s) + X_ONE) : div_sel_s;
        end else if (op_r[1:0] == 2'b00) begin
            fin_s = prod_sgn_s[XLEN-1:0];
        end else begin
            fin_s = prod_sgn_s[2*XLEN-1:XLEN];
        end
    end

    // Control FSM and datapath registers; abort returns to IDLE from any state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= S_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            op_r     <= 3'b000;
            neg_r    <= 1'b0;
            a_r      <= X_ZERO;
            prod_r   <= {(2*XLEN){1'b0}};
            result_r <= X_ZERO;
            rd_r     <= 5'd0;
        end else if (abort_i) begin
            state_r <= S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start_i) begin
                        op_r  <= op_i;
                        neg_r <= neg_s;
                        rd_r  <= reg_wr_addr_i;
                        cnt_r <= {CNT_W{1'b0}};
                        a_r   <= op_i[2] ? mag2_s : mag1_s;
                        prod_r <= {X_ZERO, (op_i[2] ? mag1_s : mag2_s)};
                        if (special_s) begin
                            result_r <= spec_res_s;
                            state_r  <= S_DONE;
                        end else begin
                            state_r  <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    prod_r <= prod_nxt_s;
                    cnt_r  <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        result_r <= fin_s;
                        state_r  <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    // An abort arriving in DONE must squash the write-back in the same cycle,
    // so the strobe is gated combinationally rather than registered.
    assign ready_o       = (state_r == S_DONE) & ~abort_i;
    assign reg_wr_en_o   = ready_o;
    assign result_o      = ready_o ? result_r : X_ZERO;
    assign reg_wr_addr_o = ready_o ? rd_r : 5'd0;
    assign hold_o        = ((state_r == S_IDLE) & start_i & ~abort_i) | (state_r == S_CALC);

endmodule

// File: tb/tb_exe_muldiv.sv
// tb_exe_muldiv: directed checks of exe_muldiv (XLEN=32) against hand-computed
// literals, plus a cycle-by-cycle comparison against a behavioural model.
module tb_exe_muldiv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        t_start = 1'b0;
    logic [2:0]  t_op = 3'd0;
    logic [31:0] t_a = 32'd0;
    logic [31:0] t_b = 32'd0;
    logic [4:0]  t_rd = 5'd0;
    logic        t_abort = 1'b0;
    logic        hold_o, ready_o, reg_wr_en_o;
    logic [31:0] result_o;
    logic [4:0]  reg_wr_addr_o;

    int tests = 0;
    int fails = 0;

    exe_muldiv #(.XLEN(32), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(t_start), .op_i(t_op),
        .op1_i(t_a), .op2_i(t_b), .reg_wr_addr_i(t_rd), .abort_i(t_abort),
        .hold_o(hold_o), .ready_o(ready_o), .result_o(result_o),
        .reg_wr_en_o(reg_wr_en_o), .reg_wr_addr_o(reg_wr_addr_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, sub;
        logic [63:0] ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        sub = ub;
        p = 64'd0;
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * sub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin if (b == 32'd0) return 32'hFFFFFFFF; return a / b; end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin if (b == 32'd0) return a; return a % b; end
        endcase
    endfunction

    function automatic logic is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        return op[2] && (b == 32'd0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
    endfunction

    // Behavioural model: when a request is accepted, the completion cycle and result.
    int          cyc = 0;
    logic        m_busy = 1'b0;
    int          m_done_at = 0;
    logic [31:0] m_res = 32'd0;
    logic [4:0]  m_rd = 5'd0;

    // Model update on each clock edge; reset cancels anything pending.
    always @(posedge clk or negedge rst_n) begin
        logic was_busy;
        if (!rst_n) begin
            m_busy = 1'b0;
        end else begin
            was_busy = m_busy;
            if (t_abort) begin
                m_busy = 1'b0;
            end else begin
                if (m_busy && cyc == m_done_at) m_busy = 1'b0;
                if (!was_busy && t_start) begin
                    m_busy    = 1'b1;
                    m_done_at = cyc + 1 + (is_special(t_op, t_a, t_b) ? 0 : 32);
                    m_res     = ref_fn(t_op, t_a, t_b);
                    m_rd      = t_rd;
                end
            end
            cyc = cyc + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle, mid-cycle, DUT outputs against the model.
    always @(negedge clk) begin
        logic e_rdy, e_hold;
        e_rdy  = rst_n && m_busy && (cyc == m_done_at) && !t_abort;
        e_hold = (!m_busy && t_start && !t_abort) || (rst_n && m_busy && cyc < m_done_at);
        chk("cyc_ready", {31'd0, ready_o}, {31'd0, e_rdy});
        chk("cyc_wr_en", {31'd0, reg_wr_en_o}, {31'd0, e_rdy});
        chk("cyc_hold", {31'd0, hold_o}, {31'd0, e_hold});
        chk("cyc_result", result_o, e_rdy ? m_res : 32'd0);
        chk("cyc_rd", {27'd0, reg_wr_addr_o}, e_rdy ? {27'd0, m_rd} : 32'd0);
    end

    // Issue one request and wait (bounded) for its strobe; check value, rd, latency.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int exp_lat);
        int n;
        logic got;
        logic [31:0] res;
        logic [4:0] addr;
        @(negedge clk); #1;
        t_start = 1'b1; t_op = op; t_a = a; t_b = b; t_rd = rd;
        n = 0; got = 1'b0; res = 32'd0; addr = 5'd0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (ready_o) begin got = 1'b1; res = result_o; addr = reg_wr_addr_o; end
            #1 t_start = 1'b0;
        end
        chk({name, "_seen"}, {31'd0, got}, 32'd1);
        chk({name, "_val"}, res, exp);
        chk({name, "_rd"}, {27'd0, addr}, {27'd0, rd});
        chk({name, "_lat"}, n, exp_lat);
    endtask

    initial begin
        int n;
        int strobes;
        logic got;
        logic [31:0] res;
        logic [4:0] addr;
        logic [2:0] rop;
        logic [31:0] ra, rb;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, ready_o}, 32'd0);
        chk("rst_result", result_o, 32'd0);
        chk("rst_rd", {27'd0, reg_wr_addr_o}, 32'd0);
        chk("rst_hold", {31'd0, hold_o}, 32'd0);
        #1 rst_n = 1'b1;

        // Directed vectors with hand-computed results
        run_op("mul",    3'd0, 32'd7,        32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, 33);
        run_op("mulh",   3'd1, 32'h80000000, 32'h80000000, 5'd2,  32'h40000000, 33);
        run_op("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFE, 33);
        run_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'd2,        5'd4,  32'hFFFFFFFF, 33);
        run_op("div",    3'd4, 32'hFFFFFFF9, 32'd2,        5'd5,  32'hFFFFFFFD, 33);
        run_op("rem",    3'd6, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF, 33);
        run_op("divu",   3'd5, 32'd100,      32'd7,        5'd7,  32'd14,       33);
        run_op("remu",   3'd7, 32'd100,      32'd7,        5'd8,  32'd2,        33);
        run_op("divu0",  3'd5, 32'h1234,     32'd0,        5'd9,  32'hFFFFFFFF, 1);
        run_op("remu0",  3'd7, 32'h1234,     32'd0,        5'd10, 32'h1234,     1);
        run_op("divovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 1);
        run_op("removf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'd0,        1);
        run_op("rem_neg", 3'd6, 32'd7,       32'hFFFFFFFE, 5'd13, 32'd1,        33);

        // Abort at CALC cycle 10, then a fresh request the following cycle
        @(negedge clk); #1;
        t_start = 1'b1; t_op = 3'd0; t_a = 32'd9; t_b = 32'd9; t_rd = 5'd14;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk); #1 t_start = 1'b0;
        end
        t_abort = 1'b1;
        @(negedge clk);
        chk("abort_ready", {31'd0, ready_o}, 32'd0);
        chk("abort_hold", {31'd0, hold_o}, 32'd0);
        #1 t_abort = 1'b0;
        run_op("post_abort", 3'd5, 32'd100, 32'd7, 5'd15, 32'd14, 33);

        // Abort during DONE suppresses the strobe in that cycle
        @(negedge clk); #1;
        t_start = 1'b1; t_op = 3'd5; t_a = 32'd5; t_b = 32'd0; t_rd = 5'd16;
        @(posedge clk); #1;
        t_start = 1'b0; t_abort = 1'b1;
        @(negedge clk);
        chk("done_abort_ready", {31'd0, ready_o}, 32'd0);
        chk("done_abort_result", result_o, 32'd0);
        #1 t_abort = 1'b0;

        // Reset asserted mid-CALC clears outputs immediately
        @(negedge clk); #1;
        t_start = 1'b1; t_op = 3'd0; t_a = 32'd3; t_b = 32'd3; t_rd = 5'd17;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk); #1 t_start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_hold", {31'd0, hold_o}, 32'd0);
        chk("midrst_ready", {31'd0, ready_o}, 32'd0);
        chk("midrst_result", result_o, 32'd0);
        chk("midrst_rd", {27'd0, reg_wr_addr_o}, 32'd0);
        @(negedge clk); #1 rst_n = 1'b1;

        // start_i during CALC is ignored
        @(negedge clk); #1;
        t_start = 1'b1; t_op = 3'd0; t_a = 32'd3; t_b = 32'd5; t_rd = 5'd3;
        n = 0; got = 1'b0; res = 32'd0; addr = 5'd0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (ready_o) begin got = 1'b1; res = result_o; addr = reg_wr_addr_o; end
            #1;
            t_start = (n == 5);
            if (n == 5) begin t_op = 3'd5; t_a = 32'd100; t_b = 32'd7; t_rd = 5'd20; end
        end
        t_start = 1'b0;
        chk("ign_seen", {31'd0, got}, 32'd1);
        chk("ign_val", res, 32'd15);
        chk("ign_rd", {27'd0, addr}, 32'd3);
        chk("ign_lat", n, 33);
        strobes = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready_o) strobes++;
        end
        chk("ign_no_second", strobes, 0);

        // Back-to-back pseudo-random operations checked against the model
        for (int i = 0; i < 8; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = (i == 3) ? 32'd0 : $urandom;
            run_op("rand", rop, ra, rb, 5'(i + 21), ref_fn(rop, ra, rb),
                   is_special(rop, ra, rb) ? 1 : 33);
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
